// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the arbiter FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU; unknown op codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'b0, (a < b)};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters; the result is
// registered with its requester ID and zero flag behind a valid/ready port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_zero
);

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           open;
    logic           accept;
    logic [3:0]     sel_op;
    logic [31:0]    sel_a, sel_b;
    logic [31:0]    alu_result;
    logic           unused_alu_zero;

    // Scan from the highest offset down so the nearest requester after 'last' wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(last_q) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    // Gating with rst_n keeps req_ready low for the whole reset, not just until the state settles.
    assign open      = rst_n && ((state_q == S_IDLE) || (state_q == S_HOLD && rsp_ready));
    assign accept    = open && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    assign sel_op = req_op[4*int'(grant_idx) +: 4];
    assign sel_a  = req_a[32*int'(grant_idx) +: 32];
    assign sel_b  = req_b[32*int'(grant_idx) +: 32];

    alu u_alu (
        .alu_op (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result),
        .zero   (unused_alu_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_HOLD;
            S_HOLD: if (rsp_ready && !accept) state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= IDW'(NREQ - 1);
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q   <= grant_idx;
                rsp_id   <= grant_idx;
                rsp_data <= alu_result;
                rsp_zero <= (alu_result == '0);
            end
        end
    end

    assign rsp_valid = (state_q == S_HOLD);

endmodule
